key_repeat_debouncer: RTL and testbench
=======================================

// Module: key_repeat_debouncer
// PURPOSE
//   Input-side conditioner for a raw board push-button (active-low KEY pin).
//   Synchronises, debounces and converts the key into clean single-cycle events:
//   press, release and auto-repeat while held. Its pulses drive count_enable/clear
//   style inputs of counters whose values go out to the hex displays.
// PARAMETERS
//   DEBOUNCE_CYCLES  4        consecutive stable cycles needed to accept a level change (>=1)
//   REPEAT_DELAY     2500000  cycles from press_pulse to first repeat_pulse (>=1)
//   REPEAT_PERIOD    500000   cycles between subsequent repeat_pulses (>=1)
// PORTS
//   clk            in   1  system clock
//   rst            in   1  synchronous reset, active-high
//   key_n          in   1  raw asynchronous key, 0 = pressed
//   repeat_en      in   1  1 = auto-repeat allowed while held
//   pressed        out  1  debounced key level, 1 = held
//   press_pulse    out  1  one-cycle pulse on accepted press
//   release_pulse  out  1  one-cycle pulse on accepted release
//   repeat_pulse   out  1  one-cycle pulse per auto-repeat tick
// BEHAVIOUR
//   - One clock, synchronous active-high reset. All outputs registered.
//   - Reset: both synchroniser flops = 1 (released), debounce and repeat counters = 0,
//     FSM = IDLE, all outputs 0. Takes effect on the clock edge where rst is sampled 1.
//   - Sync: 2-flop synchroniser on key_n; key_s = second flop (2-cycle latency).
//   - Debounce: counter increments each cycle key_s differs from the debounced level,
//     clears to 0 on any cycle they match. When the counter would reach DEBOUNCE_CYCLES
//     the debounced level flips and the counter clears.
//     Net: key_n sampled low at edge 0 and held -> pressed=1, press_pulse=1 on the
//     cycle after edge DEBOUNCE_CYCLES+1 (6 cycles for default 4). Release is symmetric.
//     Counter width = $clog2(DEBOUNCE_CYCLES+1); must never wrap.
//   - FSM states: IDLE, HOLD_WAIT, REPEATING. Repeat counter width covers max(DELAY,PERIOD).
//     IDLE: debounced press -> press_pulse, rep_cnt=0, go HOLD_WAIT.
//     HOLD_WAIT: if repeat_en, rep_cnt++; at rep_cnt==REPEAT_DELAY-1 -> repeat_pulse,
//       rep_cnt=0, go REPEATING. If repeat_en=0, rep_cnt held at 0.
//     REPEATING: if repeat_en, rep_cnt++; at REPEAT_PERIOD-1 -> repeat_pulse, rep_cnt=0.
//       repeat_en=0 -> rep_cnt=0, back to HOLD_WAIT (full delay restarts when re-enabled).
//     Any state: debounced release -> release_pulse, pressed=0, rep_cnt=0, go IDLE.
//   - Simultaneous events: release and repeat due in same cycle -> release wins,
//     repeat_pulse=0. press_pulse and repeat_pulse never both 1 (DELAY>=1).
//   - Pulses last exactly one cycle; release_pulse only after pressed was 1.
//   - Reset mid-hold: outputs 0 the next cycle, no release_pulse; if key_n still low
//     the press is re-debounced from scratch and a fresh press_pulse follows.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, repeat_en=1)
//   1 rst=1 two cycles, key_n=1 -> all outputs 0; rst=0, 20 idle cycles -> still 0.
//   2 key_n 1->0 sampled at edge 0, held -> pressed and press_pulse rise 6 cycles later,
//     press_pulse high exactly 1 cycle.
//   3 Bounce: key_n low 3 cycles, high 1, low 3, high -> no pulse, pressed stays 0;
//     then low steady -> press_pulse 6 cycles after final fall.
//   4 Hold 40 cycles after press_pulse at cycle P -> repeat_pulse at P+10, P+13, P+16...
//   5 Time release so debounced release lands on a repeat-due cycle -> release_pulse=1,
//     repeat_pulse=0 that cycle; no further repeats.
//   6 Held key, rst pulsed 1 cycle at P+12 -> outputs 0, no release_pulse; press_pulse
//     again 6 cycles after rst deasserts. repeat_en=0 while held -> no repeat_pulse;
//     re-enable -> first repeat 10 cycles later.

Source files
------------

// File: rtl/key_repeat_debouncer.sv
// Push-button conditioner: synchronises and debounces an active-low key, then
// emits single-cycle press, release and auto-repeat pulses.
module key_repeat_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 2500000,
    parameter int REPEAT_PERIOD   = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    input  logic repeat_en,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD_WAIT,
        REPEATING
    } state_t;

    state_t            state;
    logic              sync_a;
    logic              key_s;
    logic [DEB_W-1:0]  deb_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              deb_mismatch;
    logic              deb_flip;

    // key_s is active-low, so equality with the active-high level means they disagree
    assign deb_mismatch = (key_s == pressed);
    assign deb_flip     = deb_mismatch && (deb_cnt == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b1;
            key_s  <= 1'b1;
        end else begin
            sync_a <= key_n;
            key_s  <= sync_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !deb_mismatch || deb_flip) begin
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // The debounced level lives in 'pressed' so the FSM reacts on the same edge it flips
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rep_cnt       <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            if (deb_flip && pressed) begin
                pressed       <= 1'b0;
                release_pulse <= 1'b1;
                rep_cnt       <= '0;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (deb_flip) begin
                            pressed     <= 1'b1;
                            press_pulse <= 1'b1;
                            rep_cnt     <= '0;
                            state       <= HOLD_WAIT;
                        end
                    end
                    HOLD_WAIT: begin
                        if (!repeat_en) begin
                            rep_cnt <= '0;
                        end else if (rep_cnt == DELAY_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                            state        <= REPEATING;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    REPEATING: begin
                        // Disabling mid-repeat forces the full initial delay again
                        if (!repeat_en) begin
                            rep_cnt <= '0;
                            state   <= HOLD_WAIT;
                        end else if (rep_cnt == PERIOD_LAST) begin
                            repeat_pulse <= 1'b1;
                            rep_cnt      <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_repeat_debouncer.sv
// Bench for key_repeat_debouncer: cycle model of the key behaviour compared every
// cycle, plus directed scenarios with hand-computed pulse timings.
module tb_key_repeat_debouncer;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_n = 1'b1;
    logic repeat_en = 1'b1;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic repeat_pulse;

    key_repeat_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_n        (key_n),
        .repeat_en    (repeat_en),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;

    bit m_s1 = 1'b1;
    bit m_s2 = 1'b1;
    int m_run = 0;
    bit m_level = 1'b0;
    bit m_holding = 1'b0;
    bit m_first_done = 1'b0;
    int m_count = 0;
    bit exp_pressed = 1'b0;
    bit exp_press = 1'b0;
    bit exp_release = 1'b0;
    bit exp_repeat = 1'b0;

    int last_press = -1;
    int last_release = -1;
    int press_count = 0;
    int rep_q[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: a level change is accepted after DEB consecutive disagreeing samples of the
    // twice-delayed key; a held key repeats after DELAY enabled cycles, then every PERIOD.
    always @(posedge clk) begin
        bit flip;
        cyc = cyc + 1;
        exp_press = 1'b0;
        exp_release = 1'b0;
        exp_repeat = 1'b0;
        if (rst) begin
            m_s1 = 1'b1;
            m_s2 = 1'b1;
            m_run = 0;
            m_level = 1'b0;
            m_holding = 1'b0;
            m_first_done = 1'b0;
            m_count = 0;
            checking = 1'b1;
        end else begin
            if ((m_s2 == 1'b0) != m_level) m_run++;
            else m_run = 0;
            flip = (m_run == DEB);
            if (flip) m_run = 0;
            if (flip && m_level) begin
                m_level = 1'b0;
                exp_release = 1'b1;
                m_holding = 1'b0;
            end else if (flip) begin
                m_level = 1'b1;
                exp_press = 1'b1;
                m_holding = 1'b1;
                m_count = 0;
                m_first_done = 1'b0;
            end else if (m_holding) begin
                if (repeat_en) begin
                    m_count++;
                    if (m_count == (m_first_done ? PERIOD : DELAY)) begin
                        exp_repeat = 1'b1;
                        m_count = 0;
                        m_first_done = 1'b1;
                    end
                end else begin
                    m_count = 0;
                    m_first_done = 1'b0;
                end
            end
            m_s2 = m_s1;
            m_s1 = key_n;
        end
        exp_pressed = m_level;
    end

    always @(negedge clk) begin
        if (checking) begin
            check_output("pressed", pressed, exp_pressed);
            check_output("press_pulse", press_pulse, exp_press);
            check_output("release_pulse", release_pulse, exp_release);
            check_output("repeat_pulse", repeat_pulse, exp_repeat);
        end
        if (press_pulse === 1'b1) begin
            last_press = cyc;
            press_count++;
        end
        if (release_pulse === 1'b1) last_release = cyc;
        if (repeat_pulse === 1'b1) rep_q.push_back(cyc);
    end

    task automatic apply_stimulus();
        int c;
        int p;
        int e;
        int r0;
        int n0;

        // Reset and idle
        tick(2);
        check_output("reset_pressed", pressed, 1'b0);
        check_output("reset_pulses", {press_pulse, release_pulse, repeat_pulse}, 3'b000);
        rst = 1'b0;
        tick(20);
        check_output("idle_pressed", pressed, 1'b0);

        // Basic press latency and pulse width, then release
        c = cyc;
        key_n = 1'b0;
        tick(8);
        check_output("press_latency", last_press, c + 6);
        check_output("press_count", press_count, 1);
        c = cyc;
        key_n = 1'b1;
        tick(8);
        check_output("release_latency", last_release, c + 6);

        // Bounce shorter than the debounce window is ignored
        n0 = press_count;
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(1);
        key_n = 1'b0;
        tick(3);
        key_n = 1'b1;
        tick(10);
        check_output("bounce_no_press", press_count, n0);
        check_output("bounce_pressed", pressed, 1'b0);

        // Steady press then 40-cycle hold with auto-repeat
        rep_q.delete();
        c = cyc;
        key_n = 1'b0;
        p = c + 6;
        tick(8);
        check_output("press_after_bounce", last_press, p);
        tick(39);
        check_output("hold_rep_count", rep_q.size(), 11);
        check_output("hold_rep_first", rep_q[0], p + 10);
        check_output("hold_rep_second", rep_q[1], p + 13);
        check_output("hold_rep_third", rep_q[2], p + 16);
        check_output("hold_rep_last", rep_q[10], p + 40);
        c = cyc;
        key_n = 1'b1;
        tick(8);
        check_output("hold_release", last_release, c + 6);
        tick(10);
        check_output("no_rep_after_release", rep_q.size(), 13);

        // Release lands exactly on a repeat-due cycle
        rep_q.delete();
        c = cyc;
        key_n = 1'b0;
        p = c + 6;
        tick(19);
        key_n = 1'b1;
        tick(12);
        check_output("collide_release", last_release, p + 19);
        check_output("collide_rep_count", rep_q.size(), 3);
        check_output("collide_rep_last", rep_q[2], p + 16);

        // Reset mid-hold, re-debounce, then repeat_en gating
        rep_q.delete();
        r0 = last_release;
        c = cyc;
        key_n = 1'b0;
        p = c + 6;
        tick(17);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_output("midrst_pressed", pressed, 1'b0);
        tick(7);
        check_output("midrst_no_release", last_release, r0);
        check_output("midrst_repress", last_press, p + 18);
        check_output("midrst_rep_count", rep_q.size(), 1);
        repeat_en = 1'b0;
        tick(20);
        check_output("disabled_no_rep", rep_q.size(), 1);
        repeat_en = 1'b1;
        e = cyc + 1;
        tick(14);
        check_output("reenable_rep_count", rep_q.size(), 3);
        check_output("reenable_first_rep", rep_q[1], e + 9);
        repeat_en = 1'b0;
        tick(5);
        check_output("disabled_repeating", rep_q.size(), 3);
        repeat_en = 1'b1;
        e = cyc + 1;
        tick(12);
        check_output("reenable2_rep_count", rep_q.size(), 4);
        check_output("reenable2_first_rep", rep_q[3], e + 9);
        key_n = 1'b1;
        tick(10);
        check_output("final_pressed", pressed, 1'b0);
    endtask

    initial begin
        apply_stimulus();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
